// File: rtl/data_stall_bridge.sv
// data_stall_bridge: sits between a core data port and a memory model.
// The core sees grants stretched by a programmable stall and responses
// delayed by a per-response programmable delay, always returned in order.
module data_stall_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CNT_WIDTH-1:0] cfg_gnt_stall_i,
    input  logic [CNT_WIDTH-1:0] cfg_rvalid_delay_i,
    input  logic                 core_req_i,
    input  logic                 core_we_i,
    input  logic [31:0]          core_addr_i,
    input  logic [31:0]          core_wdata_i,
    input  logic [3:0]           core_be_i,
    output logic                 core_gnt_o,
    output logic                 core_rvalid_o,
    output logic [31:0]          core_rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_be_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic                 protocol_err_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    // Request-path state
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 mem_req_c;
    logic                 gnt_c;
    logic                 req_err_c;
    logic                 full_c;

    // Outstanding transactions (granted, response not yet shown to the core)
    logic [OCC_W-1:0]     outstanding_q, outstanding_d;

    // Response buffer
    logic [31:0]          buf_data_q  [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0] buf_timer_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     entry_off_c [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] entry_valid_c;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic [OCC_W-1:0]     pending_c;
    logic                 push_ok_c;
    logic                 spurious_c;
    logic                 bypass_c;
    logic                 head_ready_c;
    logic                 store_c;

    // Core-facing response outputs and sticky error
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    // Address/data/control pass straight through to memory
    assign mem_addr_o  = core_addr_i;
    assign mem_we_o    = core_we_i;
    assign mem_be_o    = core_be_i;
    assign mem_wdata_o = core_wdata_i;

    assign full_c = (outstanding_q == OCC_W'(FIFO_DEPTH));

    // Next-state and request gating for the IDLE/STALL/ISSUE controller
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        mem_req_c   = 1'b0;
        req_err_c   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (core_req_i && !full_c) begin
                        if (cfg_gnt_stall_i == '0) begin
                            mem_req_c = 1'b1;
                            if (!mem_gnt_i) begin
                                state_d = ST_ISSUE;
                            end
                        end else if (cfg_gnt_stall_i == CNT_WIDTH'(1)) begin
                            // One-cycle stall: the next cycle already issues
                            state_d = ST_ISSUE;
                        end else begin
                            // Remaining STALL cycles after this accept cycle, minus the ISSUE cycle
                            state_d     = ST_STALL;
                            stall_cnt_d = cfg_gnt_stall_i - CNT_WIDTH'(2);
                        end
                    end
                end
                ST_STALL: begin
                    if (!core_req_i) begin
                        req_err_c = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (stall_cnt_q == '0) begin
                        state_d = ST_ISSUE;
                    end else begin
                        stall_cnt_d = stall_cnt_q - CNT_WIDTH'(1);
                    end
                end
                ST_ISSUE: begin
                    if (!core_req_i) begin
                        req_err_c = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        mem_req_c = !full_c;
                        if (mem_req_c && mem_gnt_i) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_c      = mem_req_c && mem_gnt_i;
    assign mem_req_o  = mem_req_c;
    assign core_gnt_o = gnt_c;

    // Which buffer slots currently hold a response
    always_comb begin
        entry_valid_c = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            entry_off_c[i]   = PTR_W'(i) - rptr_q;
            entry_valid_c[i] = (OCC_W'(entry_off_c[i]) < count_q);
        end
    end

    // Push/pop decisions and next values for pointers, counters and outputs
    always_comb begin
        // Granted transactions whose memory response has not arrived yet
        pending_c    = outstanding_q - count_q - OCC_W'(rvalid_q);
        push_ok_c    = mem_rvalid_i && (pending_c != '0);
        spurious_c   = mem_rvalid_i && (pending_c == '0);
        head_ready_c = (count_q != '0) && (buf_timer_q[rptr_q] <= CNT_WIDTH'(1));
        // An undelayed response into an empty buffer goes straight to the output
        bypass_c     = push_ok_c && (count_q == '0) && (cfg_rvalid_delay_i == '0);
        store_c      = push_ok_c && !bypass_c;

        rptr_d  = head_ready_c ? rptr_q + PTR_W'(1) : rptr_q;
        wptr_d  = store_c ? wptr_q + PTR_W'(1) : wptr_q;
        count_d = count_q + OCC_W'(store_c) - OCC_W'(head_ready_c);

        rvalid_d = head_ready_c || bypass_c;
        rdata_d  = rdata_q;
        if (head_ready_c) begin
            rdata_d = buf_data_q[rptr_q];
        end else if (bypass_c) begin
            rdata_d = mem_rdata_i;
        end

        outstanding_d = outstanding_q + OCC_W'(gnt_c) - OCC_W'(rvalid_q);
        err_d         = err_q || spurious_c || req_err_c;
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            stall_cnt_q   <= '0;
            outstanding_q <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            outstanding_q <= outstanding_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            count_q       <= count_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    // Buffer storage: write on push, age every valid entry's timer down to zero
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (store_c && (wptr_q == PTR_W'(i))) begin
                buf_data_q[i]  <= mem_rdata_i;
                buf_timer_q[i] <= cfg_rvalid_delay_i;
            end else if (entry_valid_c[i] && (buf_timer_q[i] != '0)) begin
                buf_timer_q[i] <= buf_timer_q[i] - CNT_WIDTH'(1);
            end
        end
    end

    assign core_rvalid_o  = rvalid_q;
    assign core_rdata_o   = rdata_q;
    assign protocol_err_o = err_q;

endmodule
